// File: rtl/hsadc_sample_packetizer.sv
// Packs 16-bit ADC samples into fixed-length byte packets: header, sequence
// number, then each sample MSB first, with tlast on the final byte.
module hsadc_sample_packetizer #(
  parameter int          SAMPLES_PER_PACKET = 32,
  parameter logic [7:0]  HEADER_BYTE        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [7:0]  seq_num
);

  localparam int CW = $clog2(SAMPLES_PER_PACKET) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(SAMPLES_PER_PACKET - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_SEQ  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_MSB  = 3'd4;
  localparam logic [2:0] ST_LSB  = 3'd5;

  logic [2:0]    r_state;
  logic [7:0]    r_tdata;
  logic          r_tvalid;
  logic          r_tlast;
  logic [7:0]    r_seq;
  logic [CW-1:0] r_count;
  logic [7:0]    r_lsb;

  logic          w_last_sample;
  logic          w_s_ready;

  assign w_last_sample = (r_count == LAST_IDX);

  // The sample fetch only happens in a cycle where the current byte leaves,
  // so ready follows downstream ready and never looks at s_axis_tvalid.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_s_ready = 1'b0;
    case (r_state)
      ST_WAIT: w_s_ready = 1'b1;
      ST_SEQ:  w_s_ready = m_axis_tready;
      ST_LSB:  w_s_ready = m_axis_tready & ~w_last_sample;
      default: w_s_ready = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tdata  <= 8'h00;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_seq    <= 8'h00;
      r_count  <= '0;
      r_lsb    <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && s_axis_tvalid) begin
            r_tdata  <= HEADER_BYTE;
            r_tvalid <= 1'b1;
            r_state  <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (m_axis_tready) begin
            r_tdata <= r_seq;
            r_state <= ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (m_axis_tready) begin
            if (s_axis_tvalid) begin
              r_tdata <= s_axis_tdata[15:8];
              r_lsb   <= s_axis_tdata[7:0];
              r_state <= ST_MSB;
            end else begin
              r_tvalid <= 1'b0;
              r_state  <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (s_axis_tvalid) begin
            r_tdata  <= s_axis_tdata[15:8];
            r_lsb    <= s_axis_tdata[7:0];
            r_tvalid <= 1'b1;
            r_state  <= ST_MSB;
          end
        end
        ST_MSB: begin
          if (m_axis_tready) begin
            r_tdata <= r_lsb;
            r_tlast <= w_last_sample;
            r_state <= ST_LSB;
          end
        end
        ST_LSB: begin
          if (m_axis_tready) begin
            if (w_last_sample) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_count  <= '0;
              r_seq    <= r_seq + 8'd1;
              r_state  <= ST_IDLE;
            end else begin
              r_count <= r_count + CW'(1);
              if (s_axis_tvalid) begin
                r_tdata <= s_axis_tdata[15:8];
                r_lsb   <= s_axis_tdata[7:0];
                r_state <= ST_MSB;
              end else begin
                r_tvalid <= 1'b0;
                r_state  <= ST_WAIT;
              end
            end
          end
        end
        default: begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign seq_num       = r_seq;

endmodule

// File: tb/tb_hsadc_sample_packetizer.sv
// Directed bench for hsadc_sample_packetizer with 4 samples per packet.
module tb_hsadc_sample_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  seq_num;

  hsadc_sample_packetizer #(
    .SAMPLES_PER_PACKET(4),
    .HEADER_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .seq_num(seq_num)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] src[$];
  logic [7:0]  obytes[$];
  logic        olast[$];
  logic [7:0]  exp_b[$];
  logic        exp_l[$];
  logic        src_en;
  int          cyc;
  int          vrun;
  int          maxrun;
  int          first_bt;
  int          last_bt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s_axis_tvalid = src_en && (src.size() != 0);
    s_axis_tdata  = (src.size() != 0) ? src[0] : 16'h0000;
  endtask

  // Transfers are recorded on the falling edge, where inputs and registered
  // outputs both hold the values the next rising edge will act on.
  task automatic cycle();
    @(negedge clk);
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      obytes.push_back(m_axis_tdata);
      olast.push_back(m_axis_tlast);
      if (first_bt < 0) first_bt = cyc;
      last_bt = cyc;
    end
    if (!rst && s_axis_tvalid && s_axis_tready) void'(src.pop_front());
    if (m_axis_tvalid) begin
      vrun++;
      if (vrun > maxrun) maxrun = vrun;
    end else begin
      vrun = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_for_byte(input logic [7:0] v, input string tag);
    int guard = 0;
    while (!(m_axis_tvalid && m_axis_tdata == v) && guard < 200) begin
      cycle();
      guard++;
    end
    check({tag, "_found"}, (m_axis_tvalid && m_axis_tdata == v), 1);
  endtask

  task automatic exp_pkt(input logic [7:0] sq, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    logic [15:0] s [4];
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    exp_b.push_back(8'hA5); exp_l.push_back(1'b0);
    exp_b.push_back(sq);    exp_l.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_b.push_back(s[i][15:8]); exp_l.push_back(1'b0);
      exp_b.push_back(s[i][7:0]);  exp_l.push_back(i == 3);
    end
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    check({tag, "_len"}, obytes.size(), exp_b.size());
    n = (obytes.size() < exp_b.size()) ? obytes.size() : exp_b.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), {olast[i], obytes[i]}, {exp_l[i], exp_b[i]});
    obytes.delete(); olast.delete(); exp_b.delete(); exp_l.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; enable = 1'b0; src_en = 1'b1; m_axis_tready = 1'b1;
    s_axis_tdata = 16'h0000; s_axis_tvalid = 1'b0;
    cyc = 0; vrun = 0; maxrun = 0; first_bt = -1; last_bt = -1;

    // Reset state
    run(3);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 8'h00);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_seq", seq_num, 8'h00);
    check("rst_s_tready", s_axis_tready, 0);
    rst = 1'b0;

    // Continuous packet
    enable = 1'b1;
    src.push_back(16'h0102); src.push_back(16'h0304);
    src.push_back(16'h0506); src.push_back(16'h0708);
    drive();
    maxrun = 0;
    run(14);
    exp_pkt(8'h00, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    cmp_stream("cont");
    check("cont_run", maxrun, 10);
    check("cont_seq", seq_num, 8'h01);
    check("cont_idle_tvalid", m_axis_tvalid, 0);

    // Downstream stall on MSB 8'h03
    src.push_back(16'h0102); src.push_back(16'h0304);
    src.push_back(16'h0506); src.push_back(16'h0708);
    drive();
    wait_for_byte(8'h03, "stall");
    m_axis_tready = 1'b0;
    check("stall_s_tready0", s_axis_tready, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("stall_tdata%0d", i), m_axis_tdata, 8'h03);
      check($sformatf("stall_tvalid%0d", i), m_axis_tvalid, 1);
      check($sformatf("stall_s_tready%0d", i), s_axis_tready, 0);
    end
    m_axis_tready = 1'b1;
    run(12);
    exp_pkt(8'h01, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    cmp_stream("stall");

    // Upstream starvation after the 2nd sample
    src.push_back(16'h1112); src.push_back(16'h1314);
    drive();
    wait_for_byte(8'h14, "starve");
    cycle();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("starve_tvalid%0d", i), m_axis_tvalid, 0);
      check($sformatf("starve_s_tready%0d", i), s_axis_tready, 1);
      cycle();
    end
    src.push_back(16'h1516); src.push_back(16'h1718);
    drive();
    cycle();
    check("resume_tvalid", m_axis_tvalid, 1);
    check("resume_tdata", m_axis_tdata, 8'h15);
    run(8);
    exp_pkt(8'h02, 16'h1112, 16'h1314, 16'h1516, 16'h1718);
    cmp_stream("starve");

    // Enable low with samples pending, then dropped after the header
    enable = 1'b0;
    src.push_back(16'h4142); src.push_back(16'h4344);
    src.push_back(16'h4546); src.push_back(16'h4748);
    src.push_back(16'h2122); src.push_back(16'h2324);
    src.push_back(16'h2526); src.push_back(16'h2728);
    drive();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("en0_tvalid%0d", i), m_axis_tvalid, 0);
      check($sformatf("en0_s_tready%0d", i), s_axis_tready, 0);
    end
    enable = 1'b1;
    wait_for_byte(8'hA5, "en_hdr");
    enable = 1'b0;
    run(16);
    exp_pkt(8'h03, 16'h4142, 16'h4344, 16'h4546, 16'h4748);
    cmp_stream("en_drop");
    check("en_pending", src.size(), 4);
    check("en_no_hdr", m_axis_tvalid, 0);

    // Reset during LSB of sample 2
    enable = 1'b1;
    drive();
    wait_for_byte(8'h24, "rst_lsb");
    rst = 1'b1;
    cycle();
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_seq", seq_num, 8'h00);
    check("midrst_tlast", m_axis_tlast, 0);
    obytes.delete(); olast.delete();
    rst = 1'b0;
    src.push_back(16'h3132); src.push_back(16'h3334);
    drive();
    run(14);
    exp_pkt(8'h00, 16'h2526, 16'h2728, 16'h3132, 16'h3334);
    cmp_stream("after_rst");
    check("after_rst_seq", seq_num, 8'h01);

    // 257 back-to-back packets: sequence wraps
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("wrap_seq0", seq_num, 8'h00);
    for (int p = 0; p < 257; p++) begin
      logic [15:0] s [4];
      for (int k = 0; k < 4; k++) begin
        s[k] = 16'((p * 4 + k) * 37 + 1);
        src.push_back(s[k]);
      end
      exp_pkt(p[7:0], s[0], s[1], s[2], s[3]);
    end
    drive();
    first_bt = -1; last_bt = -1; maxrun = 0; guard = 0;
    while ((src.size() != 0 || m_axis_tvalid) && guard < 4000) begin
      cycle();
      guard++;
    end
    run(3);
    check("wrap_in_time", guard < 4000, 1);
    cmp_stream("wrap");
    check("wrap_seq_end", seq_num, 8'h01);
    check("wrap_span", last_bt - first_bt + 1, 257 * 11 - 1);
    check("wrap_maxrun", maxrun, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
